// File: rtl/serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl
//
// Computes d = a - b on WIDTH-bit unsigned operands with a single 1-bit
// subtractor cell. The cell is stepped LSB-first over WIDTH cycles while the
// borrow ripples through one flop. It is the cheap alternative to a full
// parallel subtractor chain.
//
// Flow: IDLE --start--> RUN (WIDTH cycles) --> DONE (1 cycle) --> IDLE
//
// Ports
//   clk    : system clock, rising edge
//   rst    : asynchronous, active-high reset
//   start  : request, only looked at in IDLE
//   a, b   : minuend / subtrahend, captured together with start
//   busy   : high in RUN and DONE
//   done   : one-cycle pulse; d/bor/zero are valid from this cycle on
//   d      : a - b modulo 2^WIDTH
//   bor    : final borrow, 1 iff a < b
//   zero   : 1 iff d == 0
// ---------------------------------------------------------------------------
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bor,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bor;
    logic             r_zero;

    logic             w_ai;
    logic             w_bi;
    logic             w_diff;
    logic             w_borNext;
    logic             w_last;
    logic [WIDTH-1:0] w_resNext;

    // One full-subtractor cell working on the current LSBs of the operands.
    assign w_ai      = r_opA[0];
    assign w_bi      = r_opB[0];
    assign w_diff    = w_ai ^ w_bi ^ r_borrow;
    assign w_borNext = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);

    // The difference bit enters at the MSB so that after WIDTH shifts the
    // first (LSB) result bit has arrived at position 0. Written as shift/or
    // so it stays legal for WIDTH == 1.
    assign w_resNext = (r_res >> 1) | (WIDTH'(w_diff) << (WIDTH - 1));

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Sequencer: capture operands, step the cell WIDTH times, then publish
    // the result from the value being completed on the final edge so no
    // extra cycle is spent copying it out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_opA    <= '0;
            r_opB    <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_bor    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opA    <= a;
                        r_opB    <= b;
                        r_res    <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_opA    <= r_opA >> 1;
                    r_opB    <= r_opB >> 1;
                    r_res    <= w_resNext;
                    r_borrow <= w_borNext;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_d     <= w_resNext;
                        r_bor   <= w_borNext;
                        r_zero  <= (w_resNext == '0);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status decodes straight from the state register so they are glitch-free
    // and line up exactly with the RUN/DONE cycles.
    assign busy = (r_state == S_RUN) || (r_state == S_DONE);
    assign done = (r_state == S_DONE);
    assign d    = r_d;
    assign bor  = r_bor;
    assign zero = r_zero;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_ctrl
//
// Drives a WIDTH=4 and a WIDTH=1 instance side by side. A transaction-level
// model (remaining-busy-cycles counter plus the arithmetic result of a - b)
// predicts busy/done/d/bor/zero every cycle; directed cases add literal
// expectations on top.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, bor4, zero4;
    logic [3:0] d4;

    logic       rst1, start1;
    logic [0:0] a1, b1;
    logic       busy1, done1, bor1, zero1;
    logic [0:0] d1;

    int total = 0;
    int bad   = 0;
    bit checkOn = 1'b0;

    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .d(d4), .bor(bor4), .zero(zero4)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .d(d1), .bor(bor1), .zero(zero1)
    );

    // Reference model: an accepted request keeps the unit busy for WIDTH+1
    // cycles; the last of those is the done cycle, when the arithmetic
    // result of a - b becomes visible.
    int         left4;
    logic [3:0] pendD4, md4;
    logic       pendB4, mb4, mz4;

    always @(posedge clk or posedge rst4) begin
        if (rst4) begin
            left4 = 0; md4 = '0; mb4 = 1'b0; mz4 = 1'b0;
        end else if (left4 == 0) begin
            if (start4) begin
                left4  = 4 + 1;
                pendD4 = 4'((int'(a4) - int'(b4)) & 15);
                pendB4 = (a4 < b4);
            end
        end else begin
            left4 = left4 - 1;
            if (left4 == 1) begin
                md4 = pendD4; mb4 = pendB4; mz4 = (pendD4 == 0);
            end
        end
    end

    int         left1;
    logic [0:0] pendD1, md1;
    logic       pendB1, mb1, mz1;

    always @(posedge clk or posedge rst1) begin
        if (rst1) begin
            left1 = 0; md1 = '0; mb1 = 1'b0; mz1 = 1'b0;
        end else if (left1 == 0) begin
            if (start1) begin
                left1  = 1 + 1;
                pendD1 = 1'((int'(a1) - int'(b1)) & 1);
                pendB1 = (a1 < b1);
            end
        end else begin
            left1 = left1 - 1;
            if (left1 == 1) begin
                md1 = pendD1; mb1 = pendB1; mz1 = (pendD1 == 0);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("m4 busy", 32'(busy4), 32'(left4 > 0));
            checkOutput("m4 done", 32'(done4), 32'(left4 == 1));
            checkOutput("m4 d",    32'(d4),    32'(md4));
            checkOutput("m4 bor",  32'(bor4),  32'(mb4));
            checkOutput("m4 zero", 32'(zero4), 32'(mz4));
            checkOutput("m1 busy", 32'(busy1), 32'(left1 > 0));
            checkOutput("m1 done", 32'(done1), 32'(left1 == 1));
            checkOutput("m1 d",    32'(d1),    32'(md1));
            checkOutput("m1 bor",  32'(bor1),  32'(mb1));
            checkOutput("m1 zero", 32'(zero1), 32'(mz1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        tick();
        start4 = 1'b1; a4 = a; b4 = b;
        tick();
        start4 = 1'b0;
    endtask

    task automatic applyStimulus1(input logic a, input logic b);
        tick();
        start1 = 1'b1; a1 = a; b1 = b;
        tick();
        start1 = 1'b0;
    endtask

    // Waits for done on a negative edge; returns the number of negedges
    // after the start-sampling edge's cycle, or -1 on timeout.
    task automatic waitDone4(output int cycles);
        cycles = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin
                cycles = i;
                break;
            end
        end
        checkOutput("done4 within bound", 32'(cycles >= 0), 32'd1);
    endtask

    task automatic waitDone1(output int cycles);
        cycles = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                cycles = i;
                break;
            end
        end
        checkOutput("done1 within bound", 32'(cycles >= 0), 32'd1);
    endtask

    task automatic directed4(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] expD, input logic expB, input logic expZ);
        int n;
        applyStimulus(a, b);
        waitDone4(n);
        checkOutput("lit4 latency", 32'(n), 32'd4);
        checkOutput("lit4 d",    32'(d4),    32'(expD));
        checkOutput("lit4 bor",  32'(bor4),  32'(expB));
        checkOutput("lit4 zero", 32'(zero4), 32'(expZ));
    endtask

    initial begin
        int n;
        logic [3:0] wa [4];
        logic [3:0] wb [4];
        logic [3:0] wd [4];
        logic [3:0] wbr[4];

        rst4 = 1'b1; rst1 = 1'b1;
        start4 = 1'b0; start1 = 1'b0;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0;
        tick(); tick();
        rst4 = 1'b0; rst1 = 1'b0;
        checkOn = 1'b1;

        // Reset mid-cycle then idle for 10 cycles.
        tick();
        rst4 = 1'b1;
        #1;
        checkOutput("rst busy", 32'(busy4), 32'd0);
        checkOutput("rst done", 32'(done4), 32'd0);
        tick();
        rst4 = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        directed4(4'd5, 4'd3,  4'd2,  1'b0, 1'b0);
        directed4(4'd3, 4'd5,  4'd14, 1'b1, 1'b0);
        directed4(4'd0, 4'd15, 4'd1,  1'b1, 1'b0);
        directed4(4'd9, 4'd9,  4'd0,  1'b0, 1'b1);
        directed4(4'd15, 4'd0, 4'd15, 1'b0, 1'b0);

        // Start while busy and operand churn during RUN.
        applyStimulus(4'd7, 4'd2);
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom);
            tick();
        end
        waitDone4(n);
        checkOutput("busy-start d",   32'(d4),   32'd5);
        checkOutput("busy-start bor", 32'(bor4), 32'd0);
        // First IDLE cycle start is accepted; d holds 5 meanwhile.
        applyStimulus(4'd8, 4'd1);
        @(negedge clk);
        checkOutput("hold d", 32'(d4), 32'd5);
        checkOutput("b2b busy", 32'(busy4), 32'd1);
        waitDone4(n);
        checkOutput("b2b latency", 32'(n), 32'd3);
        checkOutput("b2b d", 32'(d4), 32'd7);

        // Reset during RUN cycle 2: no done, everything cleared.
        applyStimulus(4'd5, 4'd1);
        tick();
        rst4 = 1'b1;
        #1;
        checkOutput("abort busy", 32'(busy4), 32'd0);
        checkOutput("abort done", 32'(done4), 32'd0);
        checkOutput("abort d",    32'(d4),    32'd0);
        checkOutput("abort bor",  32'(bor4),  32'd0);
        checkOutput("abort zero", 32'(zero4), 32'd0);
        tick();
        rst4 = 1'b0;
        directed4(4'd6, 4'd2, 4'd4, 1'b0, 1'b0);

        // WIDTH=1 half-subtractor sweep.
        wa = '{4'd0, 4'd0, 4'd1, 4'd1};
        wb = '{4'd0, 4'd1, 4'd0, 4'd1};
        wd = '{4'd0, 4'd1, 4'd1, 4'd0};
        wbr = '{4'd0, 4'd1, 4'd0, 4'd0};
        for (int k = 0; k < 4; k++) begin
            applyStimulus1(wa[k][0], wb[k][0]);
            waitDone1(n);
            checkOutput("w1 latency", 32'(n), 32'd1);
            checkOutput("w1 d",   32'(d1),   32'(wd[k]));
            checkOutput("w1 bor", 32'(bor1), 32'(wbr[k]));
        end

        // Random traffic on both instances, judged by the model each cycle.
        for (int i = 0; i < 400; i++) begin
            tick();
            start4 = ($urandom_range(0, 3) == 0);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            start1 = ($urandom_range(0, 2) == 0);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            if ($urandom_range(0, 150) == 0) rst4 = 1'b1;
            else rst4 = 1'b0;
        end
        start4 = 1'b0; start1 = 1'b0; rst4 = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial subtractor controller that sequences a single 1-bit subtractor cell (difference/borrow) across WIDTH cycles to compute d = a - b on WIDTH-bit unsigned operands. It latches the operands on a start handshake, steps LSB-first while propagating the borrow, then presents the full difference, final borrow and a zero flag with a one-cycle done pulse. It is the area-cheap subtraction unit for the arithmetic datapath, used where a WIDTH-bit parallel subtractor chain is not justified.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32
CNT_W, $clog2(WIDTH) with a minimum of 1, bit-counter width; derived, not overridden

Ports:
clk   input   1       system clock; all state changes on the rising edge
rst   input   1       asynchronous, active-high reset
start input   1       request; sampled only in IDLE
a     input   WIDTH   minuend; sampled together with start
b     input   WIDTH   subtrahend; sampled together with start
busy  output  1       high in RUN and DONE
done  output  1       one-cycle pulse; d/bor/zero valid from this cycle on
d     output  WIDTH   difference a - b mod 2^WIDTH
bor   output  1       final borrow out; 1 iff a < b (unsigned)
zero  output  1       1 iff d == 0

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, d=0, bor=0, zero=0; operand shift registers, borrow flop and counter cleared. Reset mid-RUN aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, latch opA=a and opB=b, set borrow=0 and cnt=0, then go to RUN. If start=0, stay in IDLE.
- RUN, once per cycle:
  - ai=opA[0], bi=opB[0].
  - diff bit = ai ^ bi ^ borrow.
  - borrow_next = (~ai & bi) | (~(ai ^ bi) & borrow).
  - Shift the diff bit into the MSB of the result shift register (right shift); shift opA and opB right.
  - cnt increments.
  - When cnt==WIDTH-1, the current edge processes the final bit: go to DONE and, on the same edge, load d from the completed result register, bor from borrow_next, and zero from (result==0).
- DONE: done=1 for exactly this one cycle; next edge returns to IDLE unconditionally.
- Latency: start sampled at edge E0; done is high in the cycle after edge E_WIDTH. That is WIDTH cycles of RUN plus one DONE cycle, so busy is high for WIDTH+1 cycles.
- Back-to-back: the earliest next start is sampled at the edge leaving DONE+1, i.e. the first IDLE cycle. Throughput is one result per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored, not queued. a/b changes during RUN have no effect because operands are latched.
- d, bor and zero hold their values from the last completed operation until the next DONE; they are not cleared by start.
- WIDTH=1: a single RUN cycle. The result equals the half-subtractor truth table: d=a^b, bor=~a&b.
- Wrap-around: the difference is modulo 2^WIDTH. Underflow is reported only through bor; there is no sign extension.

Test Plan:
- Reset then idle (WIDTH=4): assert rst mid-cycle, hold start=0 for 10 cycles -> busy=done=d=bor=zero=0 throughout, and the outputs clear immediately on rst without waiting for a clock edge.
- Basic subtraction (WIDTH=4): a=5, b=3, start for one cycle -> busy high 5 cycles, done pulses exactly once 4 cycles after the start edge, d=4'b0010, bor=0, zero=0.
- Underflow (WIDTH=4): a=3, b=5 -> d=4'b1110, bor=1, zero=0. Then a=0, b=15 -> d=4'b0001, bor=1.
- Zero result (WIDTH=4): a=9, b=9 -> d=0, bor=0, zero=1. Then a=15, b=0 -> d=15, bor=0, zero=0.
- Start while busy / operand change (WIDTH=4): start a=7, b=2, then pulse start with a=1, b=1 and toggle a/b during RUN -> a single done pulse with d=5, bor=0; the second start is ignored. A start asserted in the first IDLE cycle after done is accepted, and d holds 5 until that next done.
- Reset mid-operation and WIDTH=1 sweep: assert rst at RUN cycle 2 -> no done pulse and all outputs 0; a following a=6, b=2 gives d=4. With WIDTH=1, the inputs (0,0), (0,1), (1,0), (1,1) give d/bor = 0/0, 1/1, 1/0, 0/0.
